// File: rtl/seq_restoring_divider_if.sv
// Handshake and data bundle for the sequential restoring divider.
//   start/dividend/divisor : request side (driven by the master)
//   busy/done/quotient/remainder/div_by_zero : result side (driven by the divider)
interface seq_restoring_divider_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) ();
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

  // Requester side
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per enabled clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   ena   : global enable; when low all state holds and start is ignored
//   bus   : start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
module seq_restoring_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  seq_restoring_divider_if.slave  bus
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic [VW-1:0] dv_q, dv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   shift_c;
  logic          borrow_c;
  logic [VW-1:0] trial_c;
  logic [DW-1:0] q_next_c;
  logic [VW-1:0] r_next_c;

  // One restoring step. The partial remainder is always below the divisor,
  // so a successful subtraction fits back into VW bits.
  always_comb begin
    shift_c  = {r_q, q_q[DW-1]};
    borrow_c = (shift_c < {1'b0, dv_q});
    trial_c  = shift_c[VW-1:0] - dv_q;
    q_next_c = {q_q[DW-2:0], ~borrow_c};
    r_next_c = borrow_c ? shift_c[VW-1:0] : trial_c;
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    if (ena) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              // Divide by zero resolves immediately without iterating
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              quo_d   = '1;
              rem_d   = '0;
              dbz_d   = 1'b1;
            end else begin
              // div_by_zero only ever describes a result that is being shown
              state_d = S_RUN;
              busy_d  = 1'b1;
              done_d  = 1'b0;
              dbz_d   = 1'b0;
              q_d     = bus.dividend;
              dv_d    = bus.divisor;
              r_d     = '0;
              cnt_d   = CW'(DW - 1);
            end
          end
        end
        S_RUN: begin
          q_d = q_next_c;
          r_d = r_next_c;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quo_d   = q_next_c;
            rem_d   = r_next_c;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: an arithmetic reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_seq_restoring_divider;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  seq_restoring_divider_if #(.DW(DW), .VW(VW)) bus ();

  seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: result is plain / and %, available DW enabled cycles later
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic          m_dbz  = 1'b0;
  logic [DW-1:0] m_q    = '0;
  logic [VW-1:0] m_r    = '0;
  logic [DW-1:0] p_q    = '0;
  logic [VW-1:0] p_r    = '0;
  int            m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_q <= '0; m_r <= '0; m_left <= 0;
    end else if (ena) begin
      if (bus.start && !m_busy) begin
        if (bus.divisor == 0) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_dbz <= 1'b1;
          m_q <= '1; m_r <= '0;
        end else begin
          m_busy <= 1'b1; m_done <= 1'b0; m_dbz <= 1'b0;
          m_left <= DW;
          p_q <= DW'(bus.dividend / bus.divisor);
          p_r <= VW'(bus.dividend % bus.divisor);
        end
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_q <= p_q; m_r <= p_r;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",        32'(bus.busy),        32'(m_busy));
      chk("done",        32'(bus.done),        32'(m_done));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
      chk("quotient",    32'(bus.quotient),    32'(m_q));
      chk("remainder",   32'(bus.remainder),   32'(m_r));
    end
  end

  // Counts enabled-or-not edges after the start edge until done is seen
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic go(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int fails_before;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset values
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quo",  32'(bus.quotient), 32'd0);
    chk("rst_rem",  32'(bus.remainder), 32'd0);
    chk("rst_dbz",  32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    @(posedge clk); #1;

    // 200 / 7
    go(8'd200, 4'd7, lat);
    chk("t1_lat", 32'(lat), 32'd8);
    chk("t1_quo", 32'(bus.quotient), 32'd28);
    chk("t1_rem", 32'(bus.remainder), 32'd4);
    chk("t1_dbz", 32'(bus.div_by_zero), 32'd0);

    // Boundary operands, started from DONE
    go(8'd255, 4'd15, lat);
    chk("t2a_quo", 32'(bus.quotient), 32'd17);
    chk("t2a_rem", 32'(bus.remainder), 32'd0);
    go(8'd5, 4'd9, lat);
    chk("t2b_quo", 32'(bus.quotient), 32'd0);
    chk("t2b_rem", 32'(bus.remainder), 32'd5);

    // Divide by zero: done right after the accepting edge
    go(8'd13, 4'd0, lat);
    chk("t3_lat",  32'(lat), 32'd0);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    chk("t3_quo",  32'(bus.quotient), 32'd255);
    chk("t3_rem",  32'(bus.remainder), 32'd0);
    chk("t3_dbz",  32'(bus.div_by_zero), 32'd1);

    // Start during RUN is ignored
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t4_dbz_clr", 32'(bus.div_by_zero), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    chk("t4_lat", 32'(lat + 3), 32'd8);
    chk("t4_quo", 32'(bus.quotient), 32'd33);
    chk("t4_rem", 32'(bus.remainder), 32'd1);

    // Asynchronous reset mid-run
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_quo",  32'(bus.quotient), 32'd0);
    chk("t5_rem",  32'(bus.remainder), 32'd0);
    chk("t5_dbz",  32'(bus.div_by_zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    go(8'd9, 4'd2, lat);
    chk("t5_lat", 32'(lat), 32'd8);
    chk("t5_quo2", 32'(bus.quotient), 32'd4);
    chk("t5_rem2", 32'(bus.remainder), 32'd1);

    // Start with ena low is ignored
    ena = 1'b0;
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    ena = 1'b1;
    chk("ena_busy", 32'(bus.busy), 32'd0);
    chk("ena_quo",  32'(bus.quotient), 32'd4);

    // ena low for 3 RUN cycles stretches latency by 3
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("ena_hold_busy", 32'(bus.busy), 32'd1);
    ena = 1'b1;
    wait_done(lat);
    chk("t6_ena_lat", 32'(lat + 5), 32'd11);
    chk("t6_ena_quo", 32'(bus.quotient), 32'd28);
    chk("t6_ena_rem", 32'(bus.remainder), 32'd4);

    // Inverse of every 4x4 product
    fails_before = errors;
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        go(DW'(a * b), VW'(b), lat);
        chk("inv_quo", 32'(bus.quotient), 32'(a));
        chk("inv_rem", 32'(bus.remainder), 32'd0);
        chk("inv_lat", 32'(lat), 32'd8);
      end
    end
    if (errors != fails_before)
      $display("FAIL inverse_sweep: %0d errors in sweep expected 0", errors - fails_before);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
